// File: rtl/urv_divide_param.sv
// Iterative restoring divider for RISC-V DIV/DIVU/REM/REMU with a configurable
// number of quotient bits resolved per cycle and a stallable, killable result.
module urv_divide_param #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             d_valid_i,
  output logic             d_ready_o,
  input  logic [2:0]       d_fun_i,
  input  logic [WIDTH-1:0] d_rs1_i,
  input  logic [WIDTH-1:0] d_rs2_i,
  input  logic             x_kill_i,
  input  logic             x_stall_i,
  output logic             x_valid_o,
  output logic [WIDTH-1:0] x_rd_o
);

  localparam int N  = WIDTH / STEPS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             x_valid_q, x_valid_d;
  logic [WIDTH-1:0] x_rd_q, x_rd_d;

  logic [2:0]       fun_q, fun_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept, is_signed, is_rem;
  logic [WIDTH:0]   st_rem, st_diff;
  logic [WIDTH-1:0] st_quo;

  assign d_ready_o = (state_q == S_IDLE);
  assign x_valid_o = x_valid_q;
  assign x_rd_o    = x_rd_q;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    x_valid_d = x_valid_q;
    x_rd_d    = x_rd_q;
    fun_d     = fun_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;

    accept    = d_valid_i && (state_q == S_IDLE) && !x_kill_i;
    is_signed = fun_q[2] & ~fun_q[0];
    is_rem    = fun_q[2] & fun_q[1];

    // Partial remainder is one bit wider than the operands so the borrow of
    // each trial subtraction is never lost; quo_q shifts dividend bits out
    // of its top while quotient bits enter at the bottom.
    st_rem = rem_q;
    st_quo = quo_q;
    for (int i = 0; i < STEPS; i++) begin
      st_diff = {st_rem[WIDTH-1:0], st_quo[WIDTH-1]} - {1'b0, dsr_q};
      if (!st_diff[WIDTH]) st_rem = st_diff;
      else                 st_rem = {st_rem[WIDTH-1:0], st_quo[WIDTH-1]};
      st_quo = {st_quo[WIDTH-2:0], ~st_diff[WIDTH]};
    end

    unique case (state_q)
      S_IDLE: begin
        x_valid_d = 1'b0;
        if (accept) begin
          fun_d   = d_fun_i;
          quo_d   = d_rs1_i;
          dsr_d   = d_rs2_i;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        neg_quo_d = is_signed & (quo_q[WIDTH-1] ^ dsr_q[WIDTH-1]);
        neg_rem_d = is_signed & quo_q[WIDTH-1];
        quo_d     = (is_signed && quo_q[WIDTH-1]) ? -quo_q : quo_q;
        dsr_d     = (is_signed && dsr_q[WIDTH-1]) ? -dsr_q : dsr_q;
        rem_d     = '0;
        cnt_d     = CW'(N - 1);
        if (dsr_q == '0) begin
          x_rd_d    = is_rem ? quo_q : '1;
          x_valid_d = 1'b1;
          state_d   = S_DONE;
        end else if (is_signed && quo_q == MOST_NEG && dsr_q == '1) begin
          x_rd_d    = is_rem ? '0 : quo_q;
          x_valid_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        rem_d = st_rem;
        quo_d = st_quo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        if (is_rem) x_rd_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        else        x_rd_d = neg_quo_q ? -quo_q : quo_q;
        x_valid_d = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        if (!x_stall_i) begin
          x_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        x_valid_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    if (x_kill_i && state_q != S_IDLE) begin
      x_valid_d = 1'b0;
      state_d   = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      x_valid_q <= 1'b0;
      x_rd_q    <= '0;
    end else begin
      state_q   <= state_d;
      x_valid_q <= x_valid_d;
      x_rd_q    <= x_rd_d;
    end
  end

  // NOTE: datapath registers are always written before being read, so they carry no reset.
  always_ff @(posedge clk_i) begin
    fun_q     <= fun_d;
    quo_q     <= quo_d;
    dsr_q     <= dsr_d;
    rem_q     <= rem_d;
    neg_quo_q <= neg_quo_d;
    neg_rem_q <= neg_rem_d;
    cnt_q     <= cnt_d;
  end

endmodule

// File: tb/tb_urv_divide_param.sv
// Directed bench for urv_divide_param: a one-step and a four-step instance
// (32-bit), checking results, latency, stall, kill and asynchronous reset.
module tb_urv_divide_param;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [7:0]  lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  d_valid;
  wire  [1:0]  d_ready;
  wire  [1:0]  x_valid;
  logic [2:0]  fun;
  logic [31:0] rs1, rs2;
  logic        kill, stall;
  wire  [31:0] x_rd0, x_rd1;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  urv_divide_param #(.WIDTH(32), .STEPS(1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .d_valid_i(d_valid[0]), .d_ready_o(d_ready[0]),
    .d_fun_i(fun), .d_rs1_i(rs1), .d_rs2_i(rs2), .x_kill_i(kill), .x_stall_i(stall),
    .x_valid_o(x_valid[0]), .x_rd_o(x_rd0)
  );

  urv_divide_param #(.WIDTH(32), .STEPS(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .d_valid_i(d_valid[1]), .d_ready_o(d_ready[1]),
    .d_fun_i(fun), .d_rs1_i(rs1), .d_rs2_i(rs2), .x_kill_i(kill), .x_stall_i(stall),
    .x_valid_o(x_valid[1]), .x_rd_o(x_rd1)
  );

  vec_t basic_v [10] = '{
    '{3'b100, 32'd100,        32'd7,        32'd14,         8'd35},
    '{3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF,   8'd35},
    '{3'b100, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2,   8'd35},
    '{3'b110, 32'd100,        32'hFFFFFFF9, 32'd2,          8'd35},
    '{3'b101, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC,   8'd35},
    '{3'b111, 32'hFFFFFFF9,   32'd2,        32'd1,          8'd35},
    '{3'b000, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC,   8'd35},
    '{3'b100, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,          8'd35},
    '{3'b111, 32'h12345678,   32'h1000,     32'h678,        8'd35},
    '{3'b111, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,   8'd35}
  };

  vec_t special_v [6] = '{
    '{3'b101, 32'd5,          32'd0,        32'hFFFFFFFF,   8'd2},
    '{3'b111, 32'd5,          32'd0,        32'd5,          8'd2},
    '{3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,   8'd2},
    '{3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,          8'd2},
    '{3'b100, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF,   8'd2},
    '{3'b110, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB,   8'd2}
  };

  // Drives one request on the selected instance and reports what it observed:
  // cycle of the first x_valid_o (cycle 0 = accept cycle, -1 on timeout), the
  // result, and x_valid_o / d_ready_o in the cycle after that pulse.
  task automatic run_op(input int sel, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, output int lat, output logic [31:0] rd,
                        output logic v_after, output logic rdy_after);
    int cyc;
    @(negedge clk);
    fun = f; rs1 = a; rs2 = b; d_valid[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_valid[sel] = 1'b0;
    cyc = 1; lat = -1; rd = 'x;
    while (lat < 0 && cyc <= 60) begin
      if (x_valid[sel]) begin
        lat = cyc;
        rd  = sel ? x_rd1 : x_rd0;
      end else begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    v_after   = x_valid[sel];
    rdy_after = d_ready[sel];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; d_valid = '0; fun = '0; rs1 = '0; rs2 = '0; kill = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (x_valid !== 2'b00) begin n_fails++; $display("FAIL reset_valid: got %b expected 00", x_valid); end
    n_checks++;
    if (x_rd0 !== 32'd0 || x_rd1 !== 32'd0) begin
      n_fails++; $display("FAIL reset_rd: got %h/%h expected 0/0", x_rd0, x_rd1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (d_ready !== 2'b11) begin n_fails++; $display("FAIL reset_ready: got %b expected 11", d_ready); end
  endtask

  task automatic test_vectors(input int sel, input vec_t v [], input string tag);
    int lat; logic [31:0] rd; logic va, ra;
    foreach (v[i]) begin
      run_op(sel, v[i].f, v[i].a, v[i].b, lat, rd, va, ra);
      n_checks++;
      if (lat !== int'(v[i].lat)) begin
        n_fails++; $display("FAIL %s[%0d]_latency: got %0d expected %0d", tag, i, lat, v[i].lat);
      end
      n_checks++;
      if (rd !== v[i].exp) begin
        n_fails++; $display("FAIL %s[%0d]_result: got %h expected %h", tag, i, rd, v[i].exp);
      end
      n_checks++;
      if (va !== 1'b0 || ra !== 1'b1) begin
        n_fails++; $display("FAIL %s[%0d]_pulse: valid/ready after got %b/%b expected 0/1", tag, i, va, ra);
      end
    end
  endtask

  task automatic test_basic();
    test_vectors(0, basic_v, "basic");
  endtask

  task automatic test_special();
    test_vectors(0, special_v, "special");
  endtask

  task automatic test_steps4_stall();
    int cyc, held;
    vec_t s4 [2] = '{
      '{3'b100, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 8'd11},
      '{3'b110, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 8'd11}
    };
    test_vectors(1, s4, "steps4");
    stall = 1'b1;
    @(negedge clk);
    fun = 3'b101; rs1 = 32'hFFFFFFFF; rs2 = 32'h10; d_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_valid[1] = 1'b0;
    cyc = 1;
    while (!x_valid[1] && cyc <= 60) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc !== 11) begin n_fails++; $display("FAIL stall_latency: got %0d expected 11", cyc); end
    n_checks++;
    if (x_rd1 !== 32'h0FFFFFFF) begin n_fails++; $display("FAIL stall_result: got %h expected 0fffffff", x_rd1); end
    held = x_valid[1] ? 1 : 0;
    while (x_valid[1] && held < 10) begin
      if (held == 4) stall = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (x_valid[1]) begin
        held++;
        n_checks++;
        if (x_rd1 !== 32'h0FFFFFFF) begin n_fails++; $display("FAIL stall_hold_rd: got %h expected 0fffffff", x_rd1); end
      end
    end
    stall = 1'b0;
    n_checks++;
    if (held !== 4) begin n_fails++; $display("FAIL stall_valid_cycles: got %0d expected 4", held); end
  endtask

  task automatic test_kill();
    int seen;
    @(negedge clk);
    fun = 3'b100; rs1 = 32'd1000; rs2 = 32'd3; d_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_valid[0] = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    n_checks++;
    if (d_ready[0] !== 1'b1) begin n_fails++; $display("FAIL kill_ready: got %b expected 1", d_ready[0]); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (x_valid[0]) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (seen !== 0) begin n_fails++; $display("FAIL kill_no_valid: got %0d valid cycles expected 0", seen); end
    d_valid[0] = 1'b1; kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_valid[0] = 1'b0; kill = 1'b0;
    n_checks++;
    if (d_ready[0] !== 1'b1) begin n_fails++; $display("FAIL kill_blocks_accept: ready got %b expected 1", d_ready[0]); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic va, ra;
    @(negedge clk);
    fun = 3'b100; rs1 = 32'd1000; rs2 = 32'd3; d_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_valid[0] = 1'b0;
    for (int c = 1; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (x_valid !== 2'b00) begin n_fails++; $display("FAIL rst_mid_valid: got %b expected 00", x_valid); end
    n_checks++;
    if (x_rd0 !== 32'd0 || x_rd1 !== 32'd0) begin
      n_fails++; $display("FAIL rst_mid_rd: got %h/%h expected 0/0", x_rd0, x_rd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (d_ready !== 2'b11) begin n_fails++; $display("FAIL rst_mid_ready: got %b expected 11", d_ready); end
    run_op(0, 3'b101, 32'd9, 32'd3, lat, rd, va, ra);
    n_checks++;
    if (rd !== 32'd3 || lat !== 35) begin
      n_fails++; $display("FAIL rst_mid_divu: got %h at cycle %0d expected 3 at cycle 35", rd, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_steps4_stall();
    test_kill();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/urv_divide_param.md
URV_DIVIDE_PARAM -- requirements
Module: urv_divide_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and result width in bits (8..64, even).
REQ-002 The block SHALL have parameter STEPS, default 1, meaning quotient bits resolved per iteration cycle (1, 2 or 4; WIDTH divisible by STEPS).
REQ-003 The block SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port d_valid_i  input  1  request present.
REQ-006 The block SHALL have port d_ready_o  output  1  block can accept a request.
REQ-007 The block SHALL have port d_fun_i  input  3  operation: 100 DIV, 101 DIVU, 110 REM, 111 REMU; values with bit2=0 are executed as DIVU.
REQ-008 The block SHALL have ports d_rs1_i and d_rs2_i  input  WIDTH each  dividend and divisor.
REQ-009 The block SHALL have port x_kill_i  input  1  abort current or offered operation.
REQ-010 The block SHALL have port x_stall_i  input  1  consumer not ready; holds a completed result.
REQ-011 The block SHALL have port x_valid_o  output  1  x_rd_o holds a completed result.
REQ-012 The block SHALL have port x_rd_o  output  WIDTH  quotient or remainder.

Function
REQ-013 Accept SHALL occur in a cycle with d_valid_i=1, d_ready_o=1 and x_kill_i=0 (cycle 0); operands and d_fun_i are captured at that edge.
REQ-014 d_ready_o SHALL be 1 only in state IDLE.
REQ-015 States SHALL be IDLE, PREP, ITER, FIXUP and DONE.
- IDLE -> PREP on accept.
- PREP (cycle 1): form operand magnitudes (signed ops only), detect specials; go to DONE if special, else ITER.
- ITER: N = WIDTH/STEPS cycles (cycles 2..N+1), STEPS restoring-division steps per cycle, MSB first; then FIXUP.
- FIXUP (cycle N+2): negate quotient if operand signs differ; negate remainder if dividend negative; register the selected result.
- DONE: x_valid_o=1, starting cycle N+3 (normal) or cycle 2 (special).
REQ-016 DONE SHALL be held, with x_rd_o stable, while x_stall_i=1, and SHALL go to IDLE on the first cycle x_stall_i=0 (a one-cycle valid pulse when not stalled).
REQ-017 Divide by zero SHALL give quotient all-ones and remainder equal to the dividend, signed and unsigned.
REQ-018 Signed overflow (dividend = most negative, divisor = -1) SHALL give quotient = dividend and remainder = 0.
REQ-019 The internal remainder datapath SHALL be WIDTH+1 bits so that no subtract borrow is lost; results SHALL be truncated to WIDTH bits.
REQ-020 x_kill_i=1 in any non-IDLE state SHALL force IDLE at the next edge with no x_valid_o pulse; x_kill_i in IDLE SHALL block acceptance.
REQ-021 A new request SHALL be acceptable in the cycle after DONE exits.

Reset
REQ-022 rst_n_i=0 SHALL immediately force state IDLE, x_valid_o=0, x_rd_o=0, and d_ready_o=1 once rst_n_i=1 again, whatever the operation in progress.
REQ-023 Datapath registers other than x_rd_o SHALL need no reset value.

Verification
REQ-024 WIDTH=32, STEPS=1, DIV 100/7, x_stall_i=0 -> x_valid_o pulses in cycle 35 only, x_rd_o=14; REM -7/2 -> x_rd_o=0xFFFFFFFF (-1).
REQ-025 DIVU 5/0 -> x_valid_o in cycle 2, x_rd_o=0xFFFFFFFF; REMU 5/0 -> x_rd_o=5.
REQ-026 DIV 0x80000000/0xFFFFFFFF -> x_rd_o=0x80000000 in cycle 2; REM of the same operands -> x_rd_o=0.
REQ-027 x_kill_i pulse in cycle 10 of a DIV -> no x_valid_o; d_ready_o=1 in cycle 11. rst_n_i low in cycle 20 of a second DIV -> outputs zero immediately; a following DIVU 9/3 -> x_rd_o=3.
REQ-028 STEPS=4, DIVU 0xFFFFFFFF/0x10 -> x_valid_o in cycle 11, x_rd_o=0x0FFFFFFF; x_stall_i held 3 cycles -> x_valid_o high 4 cycles, x_rd_o stable.
REQ-029 Randomised run, WIDTH 8/32/64 and STEPS 1/2/4 -> every result matches the RISC-V M-extension reference model, with latency exactly N+3 or 2.
